// File: rtl/cascade_scheduler.sv
// Round-robin sharing of the generate_cascade engine among NUM_REQ requesters, with a post-cascade strip gap.
// Define CASCADE_TIMEOUT_EN to add a sticky WAIT_DONE watchdog that reports through error.
module cascade_scheduler #(
   parameter int NUM_REQ        = 2,
   parameter int num_leds       = 10,
   parameter int POS_W          = $clog2(num_leds) + 1,
   parameter int GAP_CYCLES     = 5000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                     clk_100mhz,
   input  logic                     sys_rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*POS_W-1:0] req_position,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     start_cascade,
   output logic [POS_W-1:0]         current_position,
   input  logic                     finished_cascade,
   output logic                     busy,
   output logic                     error
);

   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(num_leds - 1);

   typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_armed;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_done;
   logic               r_start;
   logic               r_busy;
   logic [POS_W-1:0]   r_pos;

   logic               w_found;
   logic [PTR_W-1:0]   w_sel;
   logic [PTR_W-1:0]   w_cand;
   int                 w_idx;
   logic [POS_W-1:0]   w_pos_raw;
   logic [POS_W-1:0]   w_pos;

   // Scan starts one past the last winner so every requester gets a turn.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      w_cand  = r_ptr;
      w_idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         w_cand = PTR_W'(w_idx);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   assign w_pos_raw = req_position[int'(w_sel)*POS_W +: POS_W];
   assign w_pos     = (w_pos_raw > LAST_POS) ? LAST_POS : w_pos_raw;

`ifdef CASCADE_TIMEOUT_EN
   logic r_error;
   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
         r_ptr   <= PTR_W'(NUM_REQ - 1);
         r_cnt   <= '0;
         r_armed <= 1'b0;
         r_grant <= '0;
         r_done  <= '0;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_pos   <= '0;
`ifdef CASCADE_TIMEOUT_EN
         r_error <= 1'b0;
`endif
      end else begin
         r_grant <= '0;
         r_done  <= '0;
         r_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant[w_sel] <= 1'b1;
                  r_start        <= 1'b1;
                  r_pos          <= w_pos;
                  r_ptr          <= w_sel;
                  r_armed        <= 1'b0;
                  r_cnt          <= '0;
                  r_state        <= WAIT_DONE;
                  r_busy         <= 1'b1;
               end
            end
            WAIT_DONE: begin
               // The start cycle itself never counts as completion.
               r_armed <= 1'b1;
               if (r_armed && finished_cascade) begin
                  r_done[r_ptr] <= 1'b1;
                  if (GAP_CYCLES == 0) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= GAP;
                     r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                  end
               end
`ifdef CASCADE_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_error <= 1'b1;
                  if (GAP_CYCLES == 0) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= GAP;
                     r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            GAP: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant            = r_grant;
   assign done             = r_done;
   assign start_cascade    = r_start;
   assign current_position = r_pos;
   assign busy             = r_busy;

endmodule

// File: tb/tb_cascade_scheduler.sv
// Scoreboard bench for cascade_scheduler: expected grants/dones queued at stimulus time, checked on DUT output.
module tb_cascade_scheduler;

   localparam int NUM_REQ  = 2;
   localparam int NLEDS    = 10;
   localparam int POS_W    = $clog2(NLEDS) + 1;
   localparam int GAP      = 50;
   localparam int TMO      = 200;
   localparam int ENG_LAT  = 100;

   logic                     clk_100mhz;
   logic                     sys_rst_n;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*POS_W-1:0] req_position;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic                     start_cascade;
   logic [POS_W-1:0]         current_position;
   logic                     finished_cascade;
   logic                     busy;
   logic                     error;

   cascade_scheduler #(
      .NUM_REQ(NUM_REQ), .num_leds(NLEDS), .POS_W(POS_W),
      .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n), .req(req),
      .req_position(req_position), .grant(grant), .done(done),
      .start_cascade(start_cascade), .current_position(current_position),
      .finished_cascade(finished_cascade), .busy(busy), .error(error)
   );

   typedef struct { int idx; int pos; } exp_t;
   typedef struct { int idx; int cyc; } done_t;

   exp_t  gnt_q[$];
   done_t done_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_end_cyc = -1;
   int cur_pos_exp  = 0;
   logic force_fin;
   logic eng_never;
   int   eng_left;

   initial clk_100mhz = 1'b0;
   always #5 clk_100mhz = ~clk_100mhz;
   always @(posedge clk_100mhz) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Engine model: finished_cascade pulses ENG_LAT cycles after the start cycle.
   initial begin
      finished_cascade = 1'b0;
      eng_left = -1;
      forever begin
         @(negedge clk_100mhz);
         finished_cascade = 1'b0;
         if (!sys_rst_n) begin
            eng_left = -1;
         end else if (start_cascade) begin
            eng_left = eng_never ? -1 : ENG_LAT;
            if (force_fin) finished_cascade = 1'b1;
         end else if (eng_left > 0) begin
            eng_left--;
            if (eng_left == 0) begin
               finished_cascade = 1'b1;
               eng_left = -1;
            end
         end
      end
   end

   // Monitor: pops scoreboard entries as grant/done pulses appear.
   exp_t               m_e;
   done_t              m_d;
   logic [NUM_REQ-1:0] m_oh;
   logic               prev_busy = 1'b0;
   logic               prev_err  = 1'b0;
   initial begin
      forever begin
         @(negedge clk_100mhz);
         if (!sys_rst_n) begin
            gnt_q.delete();
            done_q.delete();
            last_end_cyc = -1;
            prev_busy = 1'b0;
            prev_err  = 1'b0;
         end else begin
            check("start_eq_grant", int'(start_cascade), int'(|grant));
            if (|grant) begin
               if (gnt_q.size() == 0) begin
                  check("grant_unexp", int'(grant), 0);
               end else begin
                  m_e = gnt_q.pop_front();
                  m_oh = '0;
                  m_oh[m_e.idx] = 1'b1;
                  check("grant_vec", int'(grant), int'(m_oh));
                  check("grant_pos", int'(current_position), m_e.pos);
                  cur_pos_exp = m_e.pos;
                  if (last_end_cyc >= 0)
                     check("start_spacing", int'((cyc - last_end_cyc) >= GAP + 1), 1);
                  if (!eng_never) begin
                     m_d.idx = m_e.idx;
                     m_d.cyc = cyc + ENG_LAT + 1;
                     done_q.push_back(m_d);
                  end
               end
            end
            if (|done) begin
               if (done_q.size() == 0) begin
                  check("done_unexp", int'(done), 0);
               end else begin
                  m_d = done_q.pop_front();
                  m_oh = '0;
                  m_oh[m_d.idx] = 1'b1;
                  check("done_vec", int'(done), int'(m_oh));
                  check("done_cyc", cyc, m_d.cyc);
               end
               last_end_cyc = cyc;
            end
            if (error && !prev_err) last_end_cyc = cyc;
            if (prev_busy && !busy) begin
               if (last_end_cyc >= 0) check("busy_fall", cyc - last_end_cyc, GAP);
               check("pos_hold", int'(current_position), cur_pos_exp);
            end
            prev_busy = busy;
            prev_err  = error;
         end
      end
   end

   task automatic do_req(input int idx, input int pos, input int max_wait, output int waited);
      exp_t e;
      e.idx = idx;
      e.pos = (pos > NLEDS - 1) ? NLEDS - 1 : pos;
      gnt_q.push_back(e);
      req_position[idx*POS_W +: POS_W] = POS_W'(pos);
      req[idx] = 1'b1;
      waited = 0;
      while (grant[idx] !== 1'b1 && waited < max_wait) begin
         @(negedge clk_100mhz);
         waited++;
      end
      req[idx] = 1'b0;
      if (grant[idx] !== 1'b1) check("grant_wait_expired", 0, 1);
   endtask

   task automatic wait_idle(input int max_wait);
      int k = 0;
      while (busy && k < max_wait) begin
         @(negedge clk_100mhz);
         k++;
      end
      if (busy) check("idle_wait_expired", 0, 1);
   endtask

   task automatic wait_done(input int max_wait);
      int k = 0;
      while (!(|done) && k < max_wait) begin
         @(negedge clk_100mhz);
         k++;
      end
      if (!(|done)) check("done_wait_expired", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int w;
      int ng;
      int k;
      int s_cyc;
      sys_rst_n    = 1'b0;
      req          = '0;
      req_position = '0;
      force_fin    = 1'b0;
      eng_never    = 1'b0;
      repeat (3) @(negedge clk_100mhz);
      check("rst_grant", int'(grant), 0);
      check("rst_done", int'(done), 0);
      check("rst_start", int'(start_cascade), 0);
      check("rst_pos", int'(current_position), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_error", int'(error), 0);
      sys_rst_n = 1'b1;
      @(negedge clk_100mhz);
      check("idle_busy", int'(busy), 0);

      // Single request, one cycle from req to start.
      do_req(0, 5, 10, w);
      check("req_to_start", w, 1);
      wait_idle(400);

      // Clamp, plus a finish pulse in the start cycle that must be ignored.
      force_fin = 1'b1;
      do_req(1, 12, 10, w);
      @(negedge clk_100mhz);
      force_fin = 1'b0;
      wait_idle(400);

      // Request raised during GAP waits for IDLE.
      do_req(0, 2, 10, w);
      wait_done(400);
      repeat (10) @(negedge clk_100mhz);
      do_req(1, 4, 200, w);
      check("gap_pending_grant", cyc - last_end_cyc, GAP + 1);
      wait_idle(400);

      // Reset in the middle of WAIT_DONE.
      do_req(0, 6, 10, w);
      repeat (20) @(negedge clk_100mhz);
      check("pre_rst_busy", int'(busy), 1);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_pos", int'(current_position), 0);
      check("midrst_start", int'(start_cascade), 0);
      check("midrst_grant", int'(grant), 0);
      repeat (3) @(negedge clk_100mhz);
      sys_rst_n = 1'b1;
      @(negedge clk_100mhz);

      // Contention with both held: 0,1,0 then drop both.
      begin
         exp_t e;
         e.idx = 0; e.pos = 3; gnt_q.push_back(e);
         e.idx = 1; e.pos = 7; gnt_q.push_back(e);
         e.idx = 0; e.pos = 3; gnt_q.push_back(e);
      end
      req_position = {POS_W'(7), POS_W'(3)};
      req = 2'b11;
      ng = 0;
      k  = 0;
      while (ng < 3 && k < 2000) begin
         @(negedge clk_100mhz);
         k++;
         if (|grant) begin
            ng++;
            if (ng > 1) check("contend_spacing", cyc - last_end_cyc, GAP + 1);
            if (ng == 3) req = '0;
         end
      end
      check("contend_grants", ng, 3);
      req = '0;
      wait_idle(400);
      repeat (5) @(negedge clk_100mhz);

      // Engine that never finishes.
      eng_never = 1'b1;
      do_req(0, 1, 10, w);
      s_cyc = cyc;
`ifdef CASCADE_TIMEOUT_EN
      while (cyc < s_cyc + TMO - 1) @(negedge clk_100mhz);
      check("tmo_err_before", int'(error), 0);
      @(negedge clk_100mhz);
      check("tmo_err_set", int'(error), 1);
      wait_idle(400);
      eng_never = 1'b0;
      do_req(1, 2, 10, w);
      check("tmo_next_grant", w, 1);
      wait_idle(400);
      check("tmo_err_sticky", int'(error), 1);
`else
      while (cyc < s_cyc + 2*TMO) @(negedge clk_100mhz);
      check("notmo_error", int'(error), 0);
      check("notmo_busy", int'(busy), 1);
      sys_rst_n = 1'b0;
      repeat (2) @(negedge clk_100mhz);
      sys_rst_n = 1'b1;
      eng_never = 1'b0;
      @(negedge clk_100mhz);
      do_req(1, 8, 10, w);
      check("recover_grant", w, 1);
      wait_idle(400);
`endif

      repeat (5) @(negedge clk_100mhz);
      check("gnt_q_empty", gnt_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
